// File: rtl/bitwise_oper_pkg.sv
// Shared encodings for the bitwise operator: operation codes and FSM states.
// Pure declarations; no latency or flow-control behaviour.
package bitwise_oper_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND  = 2'b00;
   localparam op_t OP_OR   = 2'b01;
   localparam op_t OP_XOR  = 2'b10;
   localparam op_t OP_XNOR = 2'b11;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;

endpackage

// File: rtl/bitwise_oper_alu.sv
// Combinational WIDTH-bit bitwise operator (AND/OR/XOR/XNOR).
// Zero latency; no flow control.
module bitwise_oper_alu
   import bitwise_oper_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  op_t              op,
   output logic [WIDTH-1:0] res
);

   always_comb begin
      res = '0;
      case (op)
         OP_AND:  res = x & y;
         OP_OR:   res = x | y;
         OP_XOR:  res = x ^ y;
         OP_XNOR: res = ~(x ^ y);
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/bitwise_oper.sv
// Handshaked bitwise operator with per-beat or packet-fold mode; result registered, one cycle latency.
// in_ready = ~out_valid | out_ready, holds results while stalled; BITWISE_OPER_PARITY_EN adds out_par.
module bitwise_oper
   import bitwise_oper_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             acc_mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] co,
   output logic             out_last,
   output logic [CNT_W-1:0] out_cnt
`ifdef BITWISE_OPER_PARITY_EN
   ,
   output logic             out_par
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [0:0]       state_q, state_d;
   op_t              op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] co_q, co_d;
   logic             out_last_q, out_last_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

   logic             accept;
   logic             in_acc;
   logic [WIDTH-1:0] alu_x, alu_y, alu_res;
   op_t              alu_op;
   logic [CNT_W-1:0] cnt_inc;

   assign in_ready = ~out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   assign in_acc   = (state_q == S_ACC);

   // Inside an open packet the accumulator folds with a under the latched op.
   assign alu_x   = in_acc ? acc_q : a;
   assign alu_y   = in_acc ? a     : b;
   assign alu_op  = in_acc ? op_q  : op_t'(op);
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

   bitwise_oper_alu #(.WIDTH(WIDTH)) u_alu (
      .x   (alu_x),
      .y   (alu_y),
      .op  (alu_op),
      .res (alu_res)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q & ~out_ready;
      co_d        = co_q;
      out_last_d  = out_last_q;
      out_cnt_d   = out_cnt_q;
      if (accept) begin
         if (!in_acc) begin
            if (!acc_mode) begin
               out_valid_d = 1'b1;
               co_d        = alu_res;
               out_last_d  = in_last;
               out_cnt_d   = CNT_ONE;
            end else begin
               op_d  = op_t'(op);
               acc_d = alu_res;
               cnt_d = CNT_ONE;
               if (in_last) begin
                  out_valid_d = 1'b1;
                  co_d        = alu_res;
                  out_last_d  = 1'b1;
                  out_cnt_d   = CNT_ONE;
               end else begin
                  state_d = S_ACC;
               end
            end
         end else begin
            acc_d = alu_res;
            cnt_d = cnt_inc;
            if (in_last) begin
               out_valid_d = 1'b1;
               co_d        = alu_res;
               out_last_d  = 1'b1;
               out_cnt_d   = cnt_inc;
               state_d     = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         op_q        <= OP_AND;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         co_q        <= '0;
         out_last_q  <= 1'b0;
         out_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         co_q        <= co_d;
         out_last_q  <= out_last_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign co        = co_q;
   assign out_last  = out_last_q;
   assign out_cnt   = out_cnt_q;

`ifdef BITWISE_OPER_PARITY_EN
   logic par_q;

   // co_d equals co_q whenever no new result loads, so parity always tracks co.
   always_ff @(posedge clk) begin
      if (!rstn) par_q <= 1'b0;
      else       par_q <= ^co_d;
   end

   assign out_par = par_q;
`endif

endmodule

// File: tb/tb_bitwise_oper.sv
// Bench for bitwise_oper: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a packet-level reference model.
module tb_bitwise_oper;

   localparam int W    = 4;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   localparam logic [1:0] AND_ = 2'b00, OR_ = 2'b01, XOR_ = 2'b10, XNOR_ = 2'b11;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid, in_ready;
   logic [W-1:0]  a, b;
   logic [1:0]    op;
   logic          acc_mode, in_last;
   logic          out_valid, out_ready;
   logic [W-1:0]  co;
   logic          out_last;
   logic [CW-1:0] out_cnt;
`ifdef BITWISE_OPER_PARITY_EN
   logic          out_par;
`endif

   always #5 clk = ~clk;

   bitwise_oper #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .acc_mode  (acc_mode),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .co        (co),
      .out_last  (out_last),
      .out_cnt   (out_cnt)
`ifdef BITWISE_OPER_PARITY_EN
      ,
      .out_par   (out_par)
`endif
   );

   typedef struct {
      logic [W-1:0] co;
      logic         last;
      int           cnt;
   } res_t;

   res_t         q[$];
   bit           m_open;
   logic [1:0]   m_op;
   logic [W-1:0] m_acc;
   int           m_cnt;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] f(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [1:0] o);
      case (o)
         2'b00:   return x & y;
         2'b01:   return x | y;
         2'b10:   return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   // One clock cycle: drive, predict, then compare registered outputs after the edge.
   task automatic step(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [1:0] iop, input bit am, input bit il, input bit ordy);
      bit   exp_rdy;
      res_t r;
      in_valid = iv; a = ia; b = ib; op = iop; acc_mode = am; in_last = il; out_ready = ordy;
      #1;
      exp_rdy = (q.size() == 0) || ordy;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && exp_rdy) begin
         if (!m_open) begin
            if (!am) begin
               r.co = f(ia, ib, iop); r.last = il; r.cnt = 1;
               q.push_back(r);
            end else begin
               m_op = iop; m_acc = f(ia, ib, iop); m_cnt = 1;
               if (il) begin
                  r.co = m_acc; r.last = 1'b1; r.cnt = 1;
                  q.push_back(r);
               end else begin
                  m_open = 1'b1;
               end
            end
         end else begin
            m_acc = f(m_acc, ia, m_op);
            m_cnt++;
            if (il) begin
               r.co = m_acc; r.last = 1'b1; r.cnt = m_cnt;
               q.push_back(r);
               m_open = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
         chk("co", {28'd0, co}, {28'd0, q[0].co});
         chk("out_last", {31'd0, out_last}, {31'd0, q[0].last});
         chk("out_cnt", {30'd0, out_cnt}, (q[0].cnt > MAXC) ? MAXC : q[0].cnt);
`ifdef BITWISE_OPER_PARITY_EN
         chk("out_par", {31'd0, out_par}, {31'd0, ^q[0].co});
`endif
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      q.delete();
      m_open = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_co", {28'd0, co}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_out_cnt", {30'd0, out_cnt}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef BITWISE_OPER_PARITY_EN
      chk("rst_out_par", {31'd0, out_par}, 32'd0);
`endif
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
      acc_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      m_open = 1'b0; m_op = '0; m_acc = '0; m_cnt = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Per-beat results on consecutive cycles.
      step(1, 4'b1111, 4'b1001, XOR_, 0, 0, 1);
      chk("pb1_co", {28'd0, co}, 32'b0110);
      chk("pb1_cnt", {30'd0, out_cnt}, 32'd1);
      step(1, 4'b0110, 4'b1001, XOR_, 0, 0, 1);
      chk("pb2_co", {28'd0, co}, 32'b1111);
      step(1, 4'b1000, 4'b1001, XNOR_, 0, 0, 1);
      chk("pb3_co", {28'd0, co}, 32'b1110);
      chk("pb3_cnt", {30'd0, out_cnt}, 32'd1);

      // Three-beat XOR fold; later op changes ignored.
      step(1, 4'b0001, 4'b0010, XOR_, 1, 0, 1);
      chk("acc1_valid", {31'd0, out_valid}, 32'd0);
      step(1, 4'b0100, 4'b1111, AND_, 0, 0, 1);
      chk("acc2_valid", {31'd0, out_valid}, 32'd0);
      step(1, 4'b1000, 4'b0000, OR_, 1, 1, 1);
      chk("acc_co", {28'd0, co}, 32'b1111);
      chk("acc_last", {31'd0, out_last}, 32'd1);
      chk("acc_cnt", {30'd0, out_cnt}, 32'd3);

      // Single-beat packet.
      step(1, 4'b1100, 4'b1010, AND_, 1, 1, 1);
      chk("sb_co", {28'd0, co}, 32'b1000);
      chk("sb_last", {31'd0, out_last}, 32'd1);
      chk("sb_cnt", {30'd0, out_cnt}, 32'd1);

      // Backpressure: five stalled cycles, then pop and accept together.
      for (int i = 0; i < 5; i++) begin
         step(1, 4'b0011, 4'b0101, OR_, 0, 0, 0);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_co", {28'd0, co}, 32'b1000);
      end
      step(1, 4'b0011, 4'b0101, OR_, 0, 0, 1);
      chk("bp_rel_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_rel_co", {28'd0, co}, 32'b0111);

      // Reset discards an open packet.
      step(1, 4'b1111, 4'b0000, XOR_, 1, 0, 1);
      step(1, 4'b1111, 4'b0000, XOR_, 1, 0, 1);
      do_reset();
      step(1, 4'b0011, 4'b0101, OR_, 1, 1, 1);
      chk("rstpkt_co", {28'd0, co}, 32'b0111);
      chk("rstpkt_cnt", {30'd0, out_cnt}, 32'd1);

      // Five-beat packet saturates a 2-bit count.
      step(1, 4'b0001, 4'b0000, XOR_, 1, 0, 1);
      step(1, 4'b0010, 4'b0000, XOR_, 1, 0, 1);
      step(1, 4'b0100, 4'b0000, XOR_, 1, 0, 1);
      step(1, 4'b1000, 4'b0000, XOR_, 1, 0, 1);
      step(1, 4'b0001, 4'b0000, XOR_, 1, 1, 1);
      chk("sat_co", {28'd0, co}, 32'b1110);
      chk("sat_cnt", {30'd0, out_cnt}, 32'd3);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 249) == 0) do_reset();
         else step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 2'($urandom),
                   1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
